// File: rtl/bcd_score_counter.sv
// rtl/bcd_score_counter.sv - two-digit BCD score counter with button sync and digit scan
// Optional SCORE_WRAP_EN: wrap 99<->00 instead of saturating at the limits.
module bcd_score_counter #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic       clr_btn,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [3:0] digit_bcd,
  output logic [1:0] digit_sel,
  output logic       limit
);

  // Bit order everywhere below: {clr, dec, inc}
  logic [2:0] btn_s1, btn_s2, btn_prev, btn_pulse;
  logic       inc_ev, dec_ev, clr_ev;

  // Reset to 1 so a button held across reset release reads as already pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 3'b111;
      btn_s2   <= 3'b111;
      btn_prev <= 3'b111;
    end else begin
      btn_s1   <= {clr_btn, dec_btn, inc_btn};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign btn_pulse = btn_s2 & ~btn_prev;
  assign inc_ev    = btn_pulse[0];
  assign dec_ev    = btn_pulse[1];
  assign clr_ev    = btn_pulse[2];

  logic [3:0] tens_n, ones_n;
  logic       limit_n;

  always_comb begin
    tens_n  = bcd_tens;
    ones_n  = bcd_ones;
    limit_n = 1'b0;
    if (clr_ev) begin
      tens_n = 4'd0;
      ones_n = 4'd0;
    end else if (inc_ev && !dec_ev) begin
      if (bcd_tens == 4'd9 && bcd_ones == 4'd9) begin
        limit_n = 1'b1;
`ifdef SCORE_WRAP_EN
        tens_n = 4'd0;
        ones_n = 4'd0;
`else
        tens_n = 4'd9;
        ones_n = 4'd9;
`endif
      end else if (bcd_ones == 4'd9) begin
        ones_n = 4'd0;
        tens_n = bcd_tens + 4'd1;
      end else begin
        ones_n = bcd_ones + 4'd1;
      end
    end else if (dec_ev && !inc_ev) begin
      if (bcd_tens == 4'd0 && bcd_ones == 4'd0) begin
        limit_n = 1'b1;
`ifdef SCORE_WRAP_EN
        tens_n = 4'd9;
        ones_n = 4'd9;
`else
        tens_n = 4'd0;
        ones_n = 4'd0;
`endif
      end else if (bcd_ones == 4'd0) begin
        ones_n = 4'd9;
        tens_n = bcd_tens - 4'd1;
      end else begin
        ones_n = bcd_ones - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      limit    <= 1'b0;
    end else begin
      bcd_tens <= tens_n;
      bcd_ones <= ones_n;
      limit    <= limit_n;
    end
  end

  logic [15:0] scan_cnt;
  logic        scan_wrap;
  logic [1:0]  sel_n;

  assign scan_wrap = (scan_cnt == SCAN_DIV - 16'd1);
  assign sel_n     = scan_wrap ? {digit_sel[0], digit_sel[1]} : digit_sel;

  // digit_bcd follows the slot selected for the coming cycle, so both change together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= 16'd0;
      digit_sel <= 2'b01;
      digit_bcd <= 4'd0;
    end else begin
      scan_cnt  <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
      digit_sel <= sel_n;
      digit_bcd <= sel_n[0] ? bcd_ones : bcd_tens;
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// tb/tb_bcd_score_counter.sv - directed self-checking bench for bcd_score_counter
module tb_bcd_score_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc_btn, dec_btn, clr_btn;
  logic [3:0] bcd_tens, bcd_ones, digit_bcd;
  logic [1:0] digit_sel;
  logic       limit;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef SCORE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  bcd_score_counter #(.SCAN_DIV(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .inc_btn(inc_btn), .dec_btn(dec_btn), .clr_btn(clr_btn),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .digit_bcd(digit_bcd),
    .digit_sel(digit_sel), .limit(limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_score(input string tag, input int t, input int o);
    chk({tag, "_tens"}, int'(bcd_tens), t);
    chk({tag, "_ones"}, int'(bcd_ones), o);
  endtask

  // Called at a negedge; returns at a negedge
  task automatic press(input logic [2:0] b, input int hi, input int lo);
    {clr_btn, dec_btn, inc_btn} = b;
    repeat (hi) @(negedge clk);
    {clr_btn, dec_btn, inc_btn} = 3'b000;
    repeat (lo) @(negedge clk);
  endtask

  // Raise b, verify no change after edges 1 and 2, return just after edge 3
  task automatic press_to_edge3(input string tag, input logic [2:0] b, input int t, input int o);
    {clr_btn, dec_btn, inc_btn} = b;
    @(posedge clk); #1;
    chk_score({tag, "_e1"}, t, o);
    @(posedge clk); #1;
    chk_score({tag, "_e2"}, t, o);
    chk({tag, "_e2_limit"}, int'(limit), 0);
    @(posedge clk); #1;
  endtask

  task automatic finish_press(input string tag);
    @(posedge clk); #1;
    chk({tag, "_limit_after"}, int'(limit), 0);
    @(negedge clk);
    {clr_btn, dec_btn, inc_btn} = 3'b000;
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    logic [1:0] first_sel, other_sel, exp_sel, prev_sel;
    bit found;

    {clr_btn, dec_btn, inc_btn} = 3'b000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_score("rst", 0, 0);
    chk("rst_digit_bcd", int'(digit_bcd), 0);
    chk("rst_digit_sel", int'(digit_sel), 1);
    chk("rst_limit", int'(limit), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    repeat (5) press(3'b001, 4, 4);
    chk_score("five_inc", 0, 5);

    press(3'b001, 200, 4);
    chk_score("long_press", 0, 6);

    repeat (3) press(3'b001, 4, 4);
    chk_score("to_09", 0, 9);

    press_to_edge3("inc_09", 3'b001, 0, 9);
    chk_score("inc_09_e3", 1, 0);
    chk("inc_09_limit", int'(limit), 0);
    finish_press("inc_09");

    press_to_edge3("dec_10", 3'b010, 1, 0);
    chk_score("dec_10_e3", 0, 9);
    finish_press("dec_10");

    repeat (90) press(3'b001, 4, 4);
    chk_score("to_99", 9, 9);

    press_to_edge3("inc_99", 3'b001, 9, 9);
    chk_score("inc_99_e3", WRAP ? 0 : 9, WRAP ? 0 : 9);
    chk("inc_99_limit", int'(limit), 1);
    finish_press("inc_99");

    press(3'b100, 4, 4);
    chk_score("clr_a", 0, 0);

    press_to_edge3("dec_00", 3'b010, 0, 0);
    chk_score("dec_00_e3", WRAP ? 9 : 0, WRAP ? 9 : 0);
    chk("dec_00_limit", int'(limit), 1);
    finish_press("dec_00");

    press(3'b100, 4, 4);
    chk_score("clr_b", 0, 0);

    repeat (42) press(3'b001, 4, 4);
    chk_score("to_42", 4, 2);
    press_to_edge3("all3_42", 3'b111, 4, 2);
    chk_score("all3_42_e3", 0, 0);
    chk("all3_42_limit", int'(limit), 0);
    finish_press("all3_42");

    repeat (42) press(3'b001, 4, 4);
    chk_score("to_42b", 4, 2);
    press_to_edge3("incdec_42", 3'b011, 4, 2);
    chk_score("incdec_42_e3", 4, 2);
    chk("incdec_42_limit", int'(limit), 0);
    finish_press("incdec_42");

    repeat (5) press(3'b010, 4, 4);
    chk_score("to_37", 3, 7);

    // Align to a slot change, then expect four-cycle slots alternating 01/10
    @(posedge clk); #1;
    prev_sel = digit_sel;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (digit_sel != prev_sel) found = 1'b1;
      else prev_sel = digit_sel;
    end
    chk("scan_found_toggle", int'(found), 1);
    first_sel = digit_sel;
    other_sel = {first_sel[0], first_sel[1]};
    for (int k = 0; k < 16; k++) begin
      exp_sel = ((k / 4) % 2 == 0) ? first_sel : other_sel;
      chk("scan_sel", int'(digit_sel), int'(exp_sel));
      chk("scan_bcd", int'(digit_bcd), (exp_sel == 2'b01) ? 7 : 3);
      @(posedge clk); #1;
    end

    // Reset while inc is held and its pulse is in flight
    @(negedge clk);
    inc_btn = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_score("async_rst", 0, 0);
    chk("async_rst_sel", int'(digit_sel), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_score("held_thru_rst", 0, 0);
    inc_btn = 1'b0;
    repeat (5) @(negedge clk);
    chk_score("after_release", 0, 0);
    press(3'b001, 4, 4);
    chk_score("repress", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_score_counter.md
BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 Parameter SCAN_DIV, default 16'd50000, clk cycles per digit-scan slot, legal range 2..65535.
REQ-002 Clock is clk; reset is rst_n, asynchronous, active-low; single clock domain.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inc_btn  input  1  increment request, asynchronous to clk, active-high level.
REQ-006 dec_btn  input  1  decrement request, asynchronous to clk, active-high level.
REQ-007 clr_btn  input  1  clear request, asynchronous to clk, active-high level.
REQ-008 bcd_tens  output  4  registered tens digit of score, 0..9.
REQ-009 bcd_ones  output  4  registered ones digit of score, 0..9.
REQ-010 digit_bcd  output  4  registered time-multiplexed digit feeding the downstream seven-segment encoder.
REQ-011 digit_sel  output  2  registered one-hot digit enable: 2'b01 = ones slot, 2'b10 = tens slot.
REQ-012 limit  output  1  one-cycle pulse on an increment at 99 or a decrement at 00.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer followed by a previous-value flop; the event pulse = sync2 AND NOT prev.
REQ-014 Each event pulse SHALL be exactly one clk cycle wide per low-to-high transition, regardless of how long the button is held.
REQ-015 Score SHALL update on the 3rd rising clk edge counting from the first edge that samples the button high.
REQ-016 Event priority SHALL be clr > (inc, dec); clr sets score to 00 and suppresses limit.
REQ-017 inc and dec pulses in the same cycle without clr SHALL leave the score unchanged and limit low.
REQ-018 Increment: ones 0..8 -> ones+1; ones 9 -> ones 0, tens+1; values 10..15 never appear on any digit.
REQ-019 Decrement: ones 1..9 -> ones-1; ones 0 -> ones 9, tens-1.
REQ-020 Score boundary behaviour at 99 (inc) and 00 (dec) SHALL be as in REQ-028/REQ-029; limit pulses for one cycle in both configurations, coincident with the edge the update would occur.
REQ-021 A 16-bit scan counter SHALL count 0..SCAN_DIV-1 and wrap; on the wrap edge digit_sel toggles between 2'b01 and 2'b10.
REQ-022 digit_bcd SHALL equal bcd_ones while digit_sel = 2'b01 and bcd_tens while digit_sel = 2'b10, registered on the same edge as digit_sel, reflecting score values one cycle old at most.
REQ-023 digit_sel SHALL never be 2'b00 or 2'b11 outside reset.
REQ-024 Score changes SHALL not reset or disturb the scan counter.

Reset
REQ-025 On rst_n low: bcd_tens = 0, bcd_ones = 0, digit_bcd = 0, digit_sel = 2'b01, limit = 0, scan counter = 0, immediately and asynchronously.
REQ-026 Synchronizer and prev flops SHALL reset to 1, so a button held through reset release produces no event until released and pressed again.
REQ-027 Reset asserted mid-operation SHALL discard in-flight events; no score change occurs from any pulse pending at reset.

Configuration
REQ-028 Macro SCORE_WRAP_EN defined: inc at 99 -> 00 and dec at 00 -> 99, limit pulses.
REQ-029 Macro SCORE_WRAP_EN undefined: inc at 99 holds 99 and dec at 00 holds 00 (saturation), limit pulses.

Verification
REQ-030 Reset, then five inc_btn presses of 4 cycles each, separated by 4 low cycles -> bcd_tens=0, bcd_ones=5; a single 200-cycle press -> exactly one increment.
REQ-031 Score 09 plus one inc -> 10; score 10 plus one dec -> 09; update on the 3rd edge after first high sample.
REQ-032 Score 99 plus inc: without SCORE_WRAP_EN -> 99, limit=1 one cycle; with it -> 00, limit=1; score 00 plus dec mirrors (00 / 99).
REQ-033 inc, dec and clr rising together at score 42 -> 00, limit=0; inc and dec together at 42 -> 42.
REQ-034 SCAN_DIV=4, score 37 -> digit_sel alternates 01/10 every 4 cycles with digit_bcd 7/3 respectively.
REQ-035 rst_n pulsed low while inc_btn held and a pulse is in flight -> score 00 after release, no increment until inc_btn falls and rises again.
